// File: rtl/bfly_starve_ctrl.sv
// Starvation guard in front of a butterfly interconnect: watches per-requester wait
// time and temporarily masks every other requester so the starved one gets through.
//
// state | meaning
// IDLE  | requests pass unfiltered, rr_o advances on each granted cycle
// BOOST | only requester idx_q is forwarded, for at most BoostMax cycles
module bfly_starve_ctrl #(
   parameter int unsigned NumIn        = 32,
   parameter int unsigned NumOut       = 32,
   parameter int unsigned StarveThresh = 8,
   parameter int unsigned BoostMax     = 16,
   parameter int unsigned CntWidth     = 6
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NumIn-1:0]            req_i,
   output logic [NumIn-1:0]            gnt_o,
   output logic [NumIn-1:0]            req_o,
   input  logic [NumIn-1:0]            gnt_i,
   output logic [$clog2(NumOut)-1:0]   rr_o,
   output logic                        boost_o,
   output logic [$clog2(NumIn)-1:0]    boost_idx_o,
   output logic [15:0]                 boost_cnt_o
);

   localparam int unsigned IdxW = $clog2(NumIn);
   localparam int unsigned RrW  = $clog2(NumOut);
   localparam int unsigned DwW  = (BoostMax > 1) ? $clog2(BoostMax) : 1;

   localparam logic [CntWidth-1:0] CntMax    = '1;
   localparam logic [CntWidth-1:0] ThreshVal = CntWidth'(StarveThresh);
   localparam logic [DwW-1:0]      DwellLast = DwW'(BoostMax - 1);

   typedef enum logic {IDLE, BOOST} state_e;

   state_e                state_q, state_d;
   logic [CntWidth-1:0]   cnt_q [NumIn];
   logic [CntWidth-1:0]   cnt_d [NumIn];
   logic [IdxW-1:0]       idx_q, idx_d, starve_idx;
   logic [DwW-1:0]        dwell_q, dwell_d;
   logic [RrW-1:0]        rr_q, rr_d;
   logic [15:0]           boost_cnt_q, boost_cnt_d;
   logic [NumIn-1:0]      idx_oh;
   logic                  starve_any;
   logic                  boost_exit;

   always_comb begin
      idx_oh        = '0;
      idx_oh[idx_q] = 1'b1;
      if (rst_i) begin
         req_o = '0;
      end else if (state_q == BOOST) begin
         req_o = req_i & idx_oh;
      end else begin
         req_o = req_i;
      end
      gnt_o = gnt_i & req_o;
   end

   // Descending scan so the lowest starved index wins; a granted requester is never picked.
   always_comb begin
      starve_any = 1'b0;
      starve_idx = '0;
      for (int i = NumIn - 1; i >= 0; i--) begin
         if ((cnt_q[i] >= ThreshVal) && !gnt_o[i]) begin
            starve_any = 1'b1;
            starve_idx = IdxW'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      dwell_d     = dwell_q;
      rr_d        = rr_q;
      boost_cnt_d = boost_cnt_q;
      boost_exit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (|gnt_o) begin
               rr_d = rr_q + RrW'(1);
            end
            if (starve_any) begin
               state_d = BOOST;
               idx_d   = starve_idx;
               dwell_d = '0;
               if (boost_cnt_q != 16'hFFFF) begin
                  boost_cnt_d = boost_cnt_q + 16'd1;
               end
            end
         end
         BOOST: begin
            dwell_d = dwell_q + DwW'(1);
            if (gnt_o[idx_q] || !req_i[idx_q] || (dwell_q == DwellLast)) begin
               state_d    = IDLE;
               boost_exit = 1'b1;
            end
         end
      endcase
   end

   // Counters keep running while masked so the next starved requester is already known.
   always_comb begin
      for (int i = 0; i < NumIn; i++) begin
         if (!req_i[i] || gnt_o[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] != CntMax) begin
            cnt_d[i] = cnt_q[i] + CntWidth'(1);
         end else begin
            cnt_d[i] = cnt_q[i];
         end
         if (boost_exit && (IdxW'(i) == idx_q)) begin
            cnt_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         dwell_q     <= '0;
         rr_q        <= '0;
         boost_cnt_q <= '0;
         for (int i = 0; i < NumIn; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         dwell_q     <= dwell_d;
         rr_q        <= rr_d;
         boost_cnt_q <= boost_cnt_d;
         cnt_q       <= cnt_d;
      end
   end

   assign rr_o        = rr_q;
   assign boost_o     = (state_q == BOOST);
   assign boost_idx_o = idx_q;
   assign boost_cnt_o = boost_cnt_q;

endmodule

// File: doc/bfly_starve_ctrl.md
BFLY_STARVE_CTRL -- requirements
Module: bfly_starve_ctrl

Interface
REQ-001 The block SHALL have parameter NumIn, default 32: number of requesters, power of 2, at least 2.
REQ-002 The block SHALL have parameter NumOut, default 32: number of banks, power of 2, NumOut >= NumIn.
REQ-003 The block SHALL have parameter StarveThresh, default 8: wait cycles that mark a requester as starved, range 1..2^CntWidth-1.
REQ-004 The block SHALL have parameter BoostMax, default 16: maximum cycles spent in BOOST, at least 1.
REQ-005 The block SHALL have parameter CntWidth, default 6: width of each wait counter.
REQ-006 The block SHALL have port clk_i, input, 1 bit: the only clock, rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port req_i, input, NumIn bits: master requests.
REQ-009 The block SHALL have port gnt_o, output, NumIn bits: grants returned to masters.
REQ-010 The block SHALL have port req_o, output, NumIn bits: filtered requests sent to the butterfly network.
REQ-011 The block SHALL have port gnt_i, input, NumIn bits: grants from the network.
REQ-012 The block SHALL have port rr_o, output, $clog2(NumOut) bits: priority vector for the network's external-prio input.
REQ-013 The block SHALL have port boost_o, output, 1 bit: high while in BOOST.
REQ-014 The block SHALL have port boost_idx_o, output, $clog2(NumIn) bits: index of the boosted requester.
REQ-015 The block SHALL have port boost_cnt_o, output, 16 bits: count of BOOST entries since reset.

Function
REQ-016 The block SHALL be a two-state FSM with states IDLE (reset state) and BOOST.
REQ-017 In IDLE, req_o SHALL equal req_i.
REQ-018 In BOOST, req_o SHALL equal req_i AND onehot(idx_q); all other requests are masked.
REQ-019 gnt_o SHALL equal gnt_i AND req_o, combinationally (zero latency), in both states.
REQ-020 Wait counter cnt_q[i] SHALL load 0 when req_i[i]=0 or gnt_o[i]=1.
REQ-021 Otherwise, cnt_q[i] SHALL increment by 1, saturating at 2^CntWidth-1 with no wrap.
REQ-022 Wait counters SHALL keep counting while their requester is masked in BOOST.
REQ-023 IDLE->BOOST: when any registered cnt_q[i] >= StarveThresh, the FSM SHALL move to BOOST on the next edge and latch idx_q = lowest such i.
REQ-024 On the IDLE->BOOST edge, the dwell counter dwell_q SHALL clear to 0 and boost_cnt_o SHALL increment, saturating at 16'hFFFF.
REQ-025 Requester masking SHALL therefore start one cycle after the threshold is reached.
REQ-026 In BOOST, dwell_q SHALL increment every cycle.
REQ-027 BOOST->IDLE SHALL occur on the next edge when gnt_o[idx_q]=1, or req_i[idx_q]=0, or dwell_q = BoostMax-1; the first condition that holds ends BOOST.
REQ-028 On exit from BOOST, cnt_q[idx_q] SHALL clear to 0.
REQ-029 Re-entry into BOOST directly from the exit cycle SHALL NOT occur; at least one IDLE cycle is spent between BOOST periods.
REQ-030 rr_o SHALL be a counter that increments modulo NumOut on each edge where |(gnt_i & req_o) is true and the state is IDLE.
REQ-031 rr_o SHALL hold its value while in BOOST.
REQ-032 rr_o SHALL wrap from NumOut-1 to 0.
REQ-033 When a grant and a threshold crossing occur in the same cycle, the grant SHALL take precedence: a granted requester's counter clears and that requester is not selected.

Reset
REQ-034 While rst_i=1 at an edge, the block SHALL set state=IDLE, all cnt_q=0, idx_q=0, dwell_q=0, rr_o=0, boost_cnt_o=0.
REQ-035 While rst_i=1, req_o and gnt_o SHALL be forced to 0.
REQ-036 Reset asserted during BOOST SHALL abort BOOST at that edge; boost_o=0 in the following cycle.
REQ-037 All outputs SHALL be defined (no X) in the first cycle after reset.

Verification
(Scenarios use NumIn=4, NumOut=8, StarveThresh=3, BoostMax=4.)
REQ-038 Scenario: hold rst_i=1 with req_i=4'hF -> req_o=0, gnt_o=0, rr_o=0, boost_o=0, boost_cnt_o=0.
REQ-039 Scenario: req_i=4'b0100, gnt_i=0 for 3 cycles -> cnt_q[2]=3, then boost_o=1, boost_idx_o=2, req_o=4'b0100 with req_i=4'hF, boost_cnt_o=1.
REQ-040 Scenario: masters 1 and 3 reach 3 in the same cycle -> boost_idx_o=1; master 3 is boosted after a single IDLE cycle, provided it is still starved.
REQ-041 Scenario: in BOOST with gnt_i=0 throughout -> exit after exactly 4 BOOST cycles, cnt_q[idx]=0.
REQ-042 Scenario: in BOOST, gnt_i[idx]=1 -> gnt_o[idx]=1 in the same cycle, IDLE on the next cycle.
REQ-043 Scenario: 8 granted IDLE cycles -> rr_o steps 0..7 then back to 0; rr_o stays constant during BOOST.
REQ-044 Scenario: rst_i=1 during the second BOOST cycle -> IDLE, counters 0, boost_cnt_o=0.
